// File: rtl/key_cmd_pkg.sv
// Shared types and default timing constants for the key command generator.
// Imported by key_debouncer and key_command_gen.
package key_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DELAY   = 3'd1,
    REPEAT  = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    KEY_SIGN = 2'd0,
    KEY_UP   = 2'd1,
    KEY_DOWN = 2'd2
  } key_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF     = 32'd500_000;
  localparam int unsigned REPEAT_DELAY_CYCLES_DEF = 32'd25_000_000;
  localparam int unsigned REPEAT_RATE_CYCLES_DEF  = 32'd5_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    if (a > b) begin
      max_u = a;
    end else begin
      max_u = b;
    end
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser plus consecutive-sample debounce for one active-low key.
// Pressed is high while the debounced key level is low.
module key_debouncer
  import key_cmd_pkg::*;
#(
  parameter int unsigned DebounceCycles = DEBOUNCE_CYCLES_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Key_n,
  output logic Pressed
);

  localparam int CntW = $clog2(DebounceCycles + 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Debounce next state: a sample that matches the stable level discards any partial count.
  always_comb begin
    sync1_d = Key_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DebounceCycles - 1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers; reset to the released level.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Pressed = ~level_q;

endmodule

// File: rtl/key_command_gen.sv
// Turns three bouncing push-buttons into clean, exclusive one-cycle commands.
// Up/down auto-repeat while held; sign fires once per press.
module key_command_gen
  import key_cmd_pkg::*;
#(
  parameter int unsigned DebounceCycles    = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned RepeatDelayCycles = REPEAT_DELAY_CYCLES_DEF,
  parameter int unsigned RepeatRateCycles  = REPEAT_RATE_CYCLES_DEF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic KeyUp_n,
  input  logic KeyDown_n,
  input  logic KeySign_n,
  output logic Up,
  output logic Down,
  output logic SignSwitch
);

  localparam int unsigned RptMax = max_u(RepeatDelayCycles, RepeatRateCycles);
  localparam int          RptW   = $clog2(RptMax + 1);

  logic up_p, down_p, sign_p;

  key_debouncer #(.DebounceCycles(DebounceCycles)) u_db_up (
    .Clock(Clock), .Reset(Reset), .Key_n(KeyUp_n), .Pressed(up_p)
  );
  key_debouncer #(.DebounceCycles(DebounceCycles)) u_db_down (
    .Clock(Clock), .Reset(Reset), .Key_n(KeyDown_n), .Pressed(down_p)
  );
  key_debouncer #(.DebounceCycles(DebounceCycles)) u_db_sign (
    .Clock(Clock), .Reset(Reset), .Key_n(KeySign_n), .Pressed(sign_p)
  );

  state_t          state_q, state_d;
  key_t            owner_q, owner_d;
  logic [RptW-1:0] rpt_q, rpt_d;
  logic            up_q, up_d, down_q, down_d, sign_q, sign_d;
  logic            owner_held;

  // Command FSM: one owning key at a time, release takes priority over a repeat expiry.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rpt_d   = rpt_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    sign_d  = 1'b0;

    case (owner_q)
      KEY_SIGN: owner_held = sign_p;
      KEY_UP:   owner_held = up_p;
      KEY_DOWN: owner_held = down_p;
      default:  owner_held = 1'b0;
    endcase

    case (state_q)
      IDLE: begin
        if (sign_p) begin
          owner_d = KEY_SIGN;
          sign_d  = 1'b1;
          state_d = HOLD;
        end else if (up_p) begin
          owner_d = KEY_UP;
          up_d    = 1'b1;
          rpt_d   = RptW'(RepeatDelayCycles);
          state_d = DELAY;
        end else if (down_p) begin
          owner_d = KEY_DOWN;
          down_d  = 1'b1;
          rpt_d   = RptW'(RepeatDelayCycles);
          state_d = DELAY;
        end else begin
          state_d = IDLE;
        end
      end
      DELAY, REPEAT: begin
        if (!owner_held) begin
          rpt_d   = '0;
          state_d = RELEASE;
        end else if (rpt_q == RptW'(1)) begin
          up_d    = (owner_q == KEY_UP);
          down_d  = (owner_q == KEY_DOWN);
          rpt_d   = RptW'(RepeatRateCycles);
          state_d = REPEAT;
        end else begin
          rpt_d = rpt_q - RptW'(1);
        end
      end
      HOLD: begin
        if (!owner_held) begin
          state_d = RELEASE;
        end else begin
          state_d = HOLD;
        end
      end
      RELEASE: begin
        if (!(up_p || down_p || sign_p)) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = KEY_SIGN;
        rpt_d   = '0;
      end
    endcase
  end

  // FSM, repeat counter and registered command outputs.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      owner_q <= KEY_SIGN;
      rpt_q   <= '0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rpt_q   <= rpt_d;
      up_q    <= up_d;
      down_q  <= down_d;
      sign_q  <= sign_d;
    end
  end

  assign Up         = up_q;
  assign Down       = down_q;
  assign SignSwitch = sign_q;

endmodule

// File: tb/tb_key_command_gen.sv
// Directed bench for key_command_gen with DebounceCycles=4, RepeatDelay=20, RepeatRate=8.
// Pulse edges are logged and compared against hand-computed edge offsets.
module tb_key_command_gen;

  logic Clock     = 1'b0;
  logic Reset     = 1'b0;
  logic KeyUp_n   = 1'b1;
  logic KeyDown_n = 1'b1;
  logic KeySign_n = 1'b1;
  logic Up, Down, SignSwitch;

  int errors = 0;
  int checks = 0;
  int edge_no = 0;
  int multi_hot = 0;
  int up_log[$];
  int dn_log[$];
  int sg_log[$];
  int start;

  key_command_gen #(
    .DebounceCycles(4), .RepeatDelayCycles(20), .RepeatRateCycles(8)
  ) dut (
    .Clock(Clock), .Reset(Reset), .KeyUp_n(KeyUp_n), .KeyDown_n(KeyDown_n),
    .KeySign_n(KeySign_n), .Up(Up), .Down(Down), .SignSwitch(SignSwitch)
  );

  always #5 Clock = ~Clock;

  // Pulse logger: records the edge number at which each command was registered.
  always @(posedge Clock) begin
    edge_no = edge_no + 1;
    #1;
    if (Up === 1'b1) up_log.push_back(edge_no);
    if (Down === 1'b1) dn_log.push_back(edge_no);
    if (SignSwitch === 1'b1) sg_log.push_back(edge_no);
    if ($countones({Up, Down, SignSwitch}) > 1) multi_hot = multi_hot + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #2;
    end
  endtask

  task automatic clear_logs();
    up_log.delete();
    dn_log.delete();
    sg_log.delete();
    multi_hot = 0;
    start = edge_no + 1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick(3);
    checks++;
    if ({Up, Down, SignSwitch} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000", {Up, Down, SignSwitch});
    end
    Reset = 1'b1;
    clear_logs();
    tick(12);
    checks++;
    if (up_log.size() + dn_log.size() + sg_log.size() !== 0) begin
      errors++;
      $display("FAIL reset_idle got %0d pulses want 0", up_log.size() + dn_log.size() + sg_log.size());
    end
  endtask

  task automatic test_clean_up();
    clear_logs();
    tick(10);
    KeyUp_n = 1'b0;
    tick(15);
    KeyUp_n = 1'b1;
    tick(20);
    checks++;
    if (up_log.size() !== 1 || up_log[0] - start !== 16) begin
      errors++;
      $display("FAIL clean_up got n=%0d first=%0d want n=1 edge=16", up_log.size(),
               (up_log.size() > 0) ? up_log[0] - start : -1);
    end
    checks++;
    if (dn_log.size() + sg_log.size() !== 0) begin
      errors++;
      $display("FAIL clean_up_others got %0d pulses want 0", dn_log.size() + sg_log.size());
    end
  endtask

  task automatic test_down_repeat();
    int rel[6] = '{6, 26, 34, 42, 50, 58};
    int got;
    clear_logs();
    KeyDown_n = 1'b0;
    tick(60);
    KeyDown_n = 1'b1;
    tick(25);
    checks++;
    if (dn_log.size() !== 6) begin
      errors++;
      $display("FAIL down_repeat_count got %0d want 6", dn_log.size());
    end
    for (int i = 0; i < 6; i++) begin
      got = (i < dn_log.size()) ? dn_log[i] - start : -1;
      checks++;
      if (got !== rel[i]) begin
        errors++;
        $display("FAIL down_repeat[%0d] got edge %0d want %0d", i, got, rel[i]);
      end
    end
    checks++;
    if (up_log.size() + sg_log.size() + multi_hot !== 0) begin
      errors++;
      $display("FAIL down_repeat_exclusive got %0d stray want 0", up_log.size() + sg_log.size() + multi_hot);
    end
  endtask

  task automatic test_sign_once();
    clear_logs();
    KeySign_n = 1'b0;
    tick(100);
    KeySign_n = 1'b1;
    tick(20);
    checks++;
    if (sg_log.size() !== 1 || sg_log[0] - start !== 6) begin
      errors++;
      $display("FAIL sign_once got n=%0d first=%0d want n=1 edge=6", sg_log.size(),
               (sg_log.size() > 0) ? sg_log[0] - start : -1);
    end
    // Bounce 0,1,0,1 then stable low from relative edge 4.
    clear_logs();
    KeySign_n = 1'b0; tick(1);
    KeySign_n = 1'b1; tick(1);
    KeySign_n = 1'b0; tick(1);
    KeySign_n = 1'b1; tick(1);
    KeySign_n = 1'b0;
    tick(30);
    KeySign_n = 1'b1;
    tick(20);
    checks++;
    if (sg_log.size() !== 1 || sg_log[0] - start !== 10) begin
      errors++;
      $display("FAIL sign_bounce got n=%0d first=%0d want n=1 edge=10", sg_log.size(),
               (sg_log.size() > 0) ? sg_log[0] - start : -1);
    end
  endtask

  task automatic test_priority();
    clear_logs();
    KeyUp_n   = 1'b0;
    KeySign_n = 1'b0;
    tick(10);
    KeyDown_n = 1'b0;
    tick(30);
    KeyUp_n   = 1'b1;
    KeyDown_n = 1'b1;
    KeySign_n = 1'b1;
    tick(20);
    checks++;
    if (sg_log.size() !== 1 || sg_log[0] - start !== 6) begin
      errors++;
      $display("FAIL priority_sign got n=%0d first=%0d want n=1 edge=6", sg_log.size(),
               (sg_log.size() > 0) ? sg_log[0] - start : -1);
    end
    checks++;
    if (up_log.size() + dn_log.size() !== 0) begin
      errors++;
      $display("FAIL priority_ignored got %0d up/down pulses want 0", up_log.size() + dn_log.size());
    end
    clear_logs();
    KeyUp_n = 1'b0;
    tick(10);
    KeyUp_n = 1'b1;
    tick(20);
    checks++;
    if (up_log.size() !== 1 || up_log[0] - start !== 6) begin
      errors++;
      $display("FAIL priority_fresh_up got n=%0d first=%0d want n=1 edge=6", up_log.size(),
               (up_log.size() > 0) ? up_log[0] - start : -1);
    end
  endtask

  task automatic test_glitch();
    clear_logs();
    KeyUp_n = 1'b0;
    tick(3);
    KeyUp_n = 1'b1;
    tick(15);
    checks++;
    if (up_log.size() !== 0) begin
      errors++;
      $display("FAIL glitch got %0d up pulses want 0", up_log.size());
    end
    clear_logs();
    KeyUp_n = 1'b0;
    tick(10);
    KeyUp_n = 1'b1;
    tick(20);
    checks++;
    if (up_log.size() !== 1 || up_log[0] - start !== 6) begin
      errors++;
      $display("FAIL glitch_residual got n=%0d first=%0d want n=1 edge=6", up_log.size(),
               (up_log.size() > 0) ? up_log[0] - start : -1);
    end
  endtask

  task automatic test_reset_in_repeat();
    int rel[7] = '{6, 26, 34, 45, 65, 73, 81};
    int got;
    clear_logs();
    KeyUp_n = 1'b0;
    tick(37);
    Reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick(1);
      checks++;
      if ({Up, Down, SignSwitch} !== 3'b000) begin
        errors++;
        $display("FAIL reset_repeat_out[%0d] got %b want 000", k, {Up, Down, SignSwitch});
      end
    end
    Reset = 1'b1;
    tick(44);
    KeyUp_n = 1'b1;
    tick(25);
    checks++;
    if (up_log.size() !== 7) begin
      errors++;
      $display("FAIL reset_repeat_count got %0d want 7", up_log.size());
    end
    for (int i = 0; i < 7; i++) begin
      got = (i < up_log.size()) ? up_log[i] - start : -1;
      checks++;
      if (got !== rel[i]) begin
        errors++;
        $display("FAIL reset_repeat[%0d] got edge %0d want %0d", i, got, rel[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_up();
    test_down_repeat();
    test_sign_once();
    test_priority();
    test_glitch();
    test_reset_in_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
